// File: rtl/sm83_pkg.sv
// sm83_pkg
// Shared constants for the SM83 interrupt controller: register addresses,
// interrupt source count and bit positions, and the register select
// decode used by the CPU bus interface.
// No ports (package).
package sm83_pkg;

    // Memory-mapped register addresses
    localparam logic [15:0] ADR_IF = 16'hFF0F;
    localparam logic [15:0] ADR_IE = 16'hFFFF;

    // Number of interrupt sources and their bit positions in IF/IE
    localparam int NUM_SRC = 5;
    localparam int VBLANK  = 0;
    localparam int STAT    = 1;
    localparam int TIMER   = 2;
    localparam int SERIAL  = 3;
    localparam int JOYPAD  = 4;

    // Which controller register, if any, the CPU address selects
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_IF   = 2'd1,
        SEL_IE   = 2'd2
    } sel_e;

    function automatic sel_e decodeAdr(input logic [15:0] a);
        case (a)
            ADR_IF:  return SEL_IF;
            ADR_IE:  return SEL_IE;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sm83_edge_det.sv
// sm83_edge_det
// Parameterised rising-edge detector. Keeps a one-clock history of the
// input and flags bits that are high now but were low last clock. The
// history resets to all-ones so that anything already high when reset
// releases is treated as old, not as a fresh edge.
// Ports:
//   clk     - clock
//   n_reset - asynchronous active-low reset
//   i_d     - input levels [WIDTH-1:0]
//   o_rise  - one-clock rising-edge flags [WIDTH-1:0]
module sm83_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_hist;

    // History register; reset to ones suppresses edges from levels held through reset
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_hist <= '1;
        end else begin
            r_hist <= i_d;
        end
    end

    assign o_rise = i_d & ~r_hist;

endmodule

// File: rtl/sm83_irq_ctl.sv
// sm83_irq_ctl
// SM83 interrupt controller: IF (pending flags, 0xFF0F) and IE (enable
// mask, 0xFFFF) registers with source edge detection, CPU acknowledge,
// edge-committed CPU writes, registered reads and a combinational irq
// vector toward the CPU.
// Ports:
//   clk      - clock
//   n_reset  - asynchronous active-low reset
//   adr      - CPU address bus [15:0]
//   wdata    - CPU write data [7:0]
//   rd, wr   - CPU read / write strobes (level, may be held)
//   rdata    - registered read data [7:0]
//   rdata_oe - registered read-valid flag
//   src      - peripheral request levels [NUM_SRC-1:0]
//   irq      - pending-and-enabled requests [NUM_IRQS-1:0]
//   iack     - CPU acknowledge [NUM_IRQS-1:0]
module sm83_irq_ctl #(
    parameter int NUM_SRC  = sm83_pkg::NUM_SRC,
    parameter int NUM_IRQS = 8
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [15:0]         adr,
    input  logic [7:0]          wdata,
    input  logic                rd,
    input  logic                wr,
    output logic [7:0]          rdata,
    output logic                rdata_oe,
    input  logic [NUM_SRC-1:0]  src,
    output logic [NUM_IRQS-1:0] irq,
    input  logic [NUM_IRQS-1:0] iack
);

    import sm83_pkg::*;

    logic [NUM_SRC-1:0] r_if;
    logic [7:0]         r_ie;
    logic [NUM_SRC-1:0] w_srcRise;
    logic [0:0]         w_wrRise;
    logic               w_wrCommit;
    sel_e               w_sel;
    logic [7:0]         w_ifRead;
    logic [7:0]         w_rdNext;
    logic               w_rdValid;
    logic               w_unused;

    // Acknowledge lines above the implemented sources carry no meaning here
    assign w_unused = ^iack[NUM_IRQS-1:NUM_SRC];

    sm83_edge_det #(.WIDTH(NUM_SRC)) u_srcEdge (
        .clk     (clk),
        .n_reset (n_reset),
        .i_d     (src),
        .o_rise  (w_srcRise)
    );

    // Reusing the detector on wr makes a held strobe write exactly once, and
    // its reset-to-ones history blocks a strobe held across reset from committing
    sm83_edge_det #(.WIDTH(1)) u_wrEdge (
        .clk     (clk),
        .n_reset (n_reset),
        .i_d     (wr),
        .o_rise  (w_wrRise)
    );

    assign w_wrCommit = w_wrRise[0];
    assign w_sel      = decodeAdr(adr);

    // IF bits: a source edge beats acknowledge, which beats a CPU write
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_if <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_srcRise[i]) begin
                    r_if[i] <= 1'b1;
                end else if (iack[i]) begin
                    r_if[i] <= 1'b0;
                end else if (w_wrCommit && (w_sel == SEL_IF)) begin
                    r_if[i] <= wdata[i];
                end
            end
        end
    end

    // IE is only touched by a committed CPU write
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ie <= '0;
        end else if (w_wrCommit && (w_sel == SEL_IE)) begin
            r_ie <= wdata;
        end
    end

    // Read mux; unimplemented IF bits read back as ones
    always_comb begin
        w_ifRead              = '1;
        w_ifRead[NUM_SRC-1:0] = r_if;
        w_rdValid             = rd && (w_sel != SEL_NONE);
        w_rdNext              = 8'h00;
        if (w_rdValid) begin
            w_rdNext = (w_sel == SEL_IF) ? w_ifRead : r_ie;
        end
    end

    // Registered read port samples IF before any update on the same edge
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rdata    <= 8'h00;
            rdata_oe <= 1'b0;
        end else begin
            rdata    <= w_rdNext;
            rdata_oe <= w_rdValid;
        end
    end

    // Requests toward the CPU follow the registers with no added latency
    always_comb begin
        irq = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            irq[i] = r_if[i] & r_ie[i];
        end
    end

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// tb_sm83_irq_ctl
// Self-checking bench for sm83_irq_ctl: a table of directed single-clock
// vectors followed by hand-written multi-clock sequences for held writes,
// simultaneous set/acknowledge and reset corner cases.
module tb_sm83_irq_ctl;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] adr;
        logic [7:0]  wdata;
        logic [4:0]  src;
        logic [7:0]  iack;
        logic [7:0]  expIrq;
        logic [7:0]  expRdata;
        logic        expOe;
    } vec_t;

    logic        clk;
    logic        n_reset;
    logic [15:0] adr;
    logic [7:0]  wdata;
    logic        rd;
    logic        wr;
    logic [7:0]  rdata;
    logic        rdata_oe;
    logic [4:0]  src;
    logic [7:0]  irq;
    logic [7:0]  iack;

    int testsRun;
    int testsFailed;

    vec_t vecs [0:20];

    sm83_irq_ctl #(.NUM_SRC(5), .NUM_IRQS(8)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .adr      (adr),
        .wdata    (wdata),
        .rd       (rd),
        .wr       (wr),
        .rdata    (rdata),
        .rdata_oe (rdata_oe),
        .src      (src),
        .irq      (irq),
        .iack     (iack)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t makeVec(input logic r, input logic w, input logic [15:0] a,
                                     input logic [7:0] d, input logic [4:0] s, input logic [7:0] k,
                                     input logic [7:0] eI, input logic [7:0] eR, input logic eO);
        vec_t v;
        v.rd = r; v.wr = w; v.adr = a; v.wdata = d; v.src = s; v.iack = k;
        v.expIrq = eI; v.expRdata = eR; v.expOe = eO;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Drive one vector away from the edge, then let one rising edge pass
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rd    = v.rd;
        wr    = v.wr;
        adr   = v.adr;
        wdata = v.wdata;
        src   = v.src;
        iack  = v.iack;
        @(posedge clk);
        #1;
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput({name, ".irq"}, irq, v.expIrq);
        checkOutput({name, ".rdata"}, rdata, v.expRdata);
        checkOutput({name, ".oe"}, {7'd0, rdata_oe}, {7'd0, v.expOe});
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        n_reset = 1'b0;
        rd = 1'b0; wr = 1'b0; adr = 16'h0000; wdata = 8'h00; src = 5'h00; iack = 8'h00;

        //                 rd    wr    adr       wdata  src    iack   irq    rdata  oe
        vecs[0]  = makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[1]  = makeVec(1'b0, 1'b1, 16'hFFFF, 8'h1F, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[2]  = makeVec(1'b0, 1'b0, 16'hFFFF, 8'h00, 5'h04, 8'h00, 8'h04, 8'h00, 1'b0);
        vecs[3]  = makeVec(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h00, 8'h00, 8'h04, 8'hE4, 1'b1);
        vecs[4]  = makeVec(1'b0, 1'b0, 16'hFF0F, 8'h00, 5'h00, 8'h04, 8'h00, 8'h00, 1'b0);
        vecs[5]  = makeVec(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h00, 8'h00, 8'h00, 8'hE0, 1'b1);
        vecs[6]  = makeVec(1'b1, 1'b0, 16'hFFFF, 8'h00, 5'h00, 8'h00, 8'h00, 8'h1F, 1'b1);
        vecs[7]  = makeVec(1'b0, 1'b1, 16'hFFFF, 8'h00, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[8]  = makeVec(1'b0, 1'b0, 16'hFFFF, 8'h00, 5'h10, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[9]  = makeVec(1'b0, 1'b1, 16'hFFFF, 8'h10, 5'h00, 8'h00, 8'h10, 8'h00, 1'b0);
        vecs[10] = makeVec(1'b1, 1'b0, 16'hFFFF, 8'h00, 5'h00, 8'h00, 8'h10, 8'h10, 1'b1);
        vecs[11] = makeVec(1'b1, 1'b0, 16'hFF80, 8'h00, 5'h00, 8'h00, 8'h10, 8'h00, 1'b0);
        vecs[12] = makeVec(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h00, 8'h00, 8'h10, 8'hF0, 1'b1);
        vecs[13] = makeVec(1'b0, 1'b1, 16'hFF0E, 8'hFF, 5'h00, 8'h00, 8'h10, 8'h00, 1'b0);
        vecs[14] = makeVec(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h00, 8'h00, 8'h10, 8'hF0, 1'b1);
        vecs[15] = makeVec(1'b0, 1'b1, 16'hFF0F, 8'hE0, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[16] = makeVec(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h00, 8'h00, 8'h00, 8'hE0, 1'b1);
        vecs[17] = makeVec(1'b0, 1'b1, 16'hFF0F, 8'h00, 5'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[18] = makeVec(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h00, 8'h00, 8'h00, 8'hE1, 1'b1);
        vecs[19] = makeVec(1'b0, 1'b1, 16'hFFFF, 8'h1F, 5'h00, 8'h00, 8'h01, 8'h00, 1'b0);
        vecs[20] = makeVec(1'b0, 1'b0, 16'hFFFF, 8'h00, 5'h00, 8'hFF, 8'h00, 8'h00, 1'b0);

        // Outputs while reset is asserted
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.irq", irq, 8'h00);
        checkOutput("reset.rdata", rdata, 8'h00);
        checkOutput("reset.oe", {7'd0, rdata_oe}, 8'h00);
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Simultaneous source edge and acknowledge on the same bit
        runVec("sim.set",   makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h02, 8'h00, 8'h02, 8'h00, 1'b0));
        runVec("sim.fall",  makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 8'h00, 8'h02, 8'h00, 1'b0));
        runVec("sim.both",  makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h02, 8'h02, 8'h02, 8'h00, 1'b0));
        runVec("sim.ack",   makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h02, 8'h02, 8'h00, 8'h00, 1'b0));
        runVec("sim.idle",  makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0));

        // Held write commits once; src[0] rises on the third held clock
        runVec("held.c1",   makeVec(1'b0, 1'b1, 16'hFF0F, 8'h03, 5'h00, 8'h00, 8'h03, 8'h00, 1'b0));
        runVec("held.c2",   makeVec(1'b0, 1'b1, 16'hFF0F, 8'h03, 5'h00, 8'h00, 8'h03, 8'h00, 1'b0));
        runVec("held.c3",   makeVec(1'b0, 1'b1, 16'hFF0F, 8'h03, 5'h01, 8'h00, 8'h03, 8'h00, 1'b0));
        runVec("held.c4",   makeVec(1'b0, 1'b1, 16'hFF0F, 8'h03, 5'h01, 8'h00, 8'h03, 8'h00, 1'b0));
        runVec("held.rd",   makeVec(1'b1, 1'b1, 16'hFF0F, 8'h03, 5'h01, 8'h00, 8'h03, 8'hE3, 1'b1));
        runVec("held.ack",  makeVec(1'b0, 1'b1, 16'hFF0F, 8'h03, 5'h01, 8'h03, 8'h00, 8'h00, 1'b0));
        runVec("held.nore", makeVec(1'b0, 1'b1, 16'hFF0F, 8'h03, 5'h01, 8'h00, 8'h00, 8'h00, 1'b0));
        runVec("held.end",  makeVec(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h00, 8'h00, 8'h00, 8'hE0, 1'b1));

        // Sources held high across reset release raise nothing
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; iack = 8'h00; src = 5'h1F;
        n_reset = 1'b0;
        #1;
        checkOutput("rst2.irq", irq, 8'h00);
        checkOutput("rst2.oe", {7'd0, rdata_oe}, 8'h00);
        @(negedge clk);
        n_reset = 1'b1;
        runVec("rel.idle",  makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h1F, 8'h00, 8'h00, 8'h00, 1'b0));
        runVec("rel.ie",    makeVec(1'b0, 1'b1, 16'hFFFF, 8'h1F, 5'h1F, 8'h00, 8'h00, 8'h00, 1'b0));
        runVec("rel.rdif",  makeVec(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h1F, 8'h00, 8'h00, 8'hE0, 1'b1));
        runVec("rel.src0",  makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        runVec("rel.src1",  makeVec(1'b0, 1'b0, 16'h0000, 8'h00, 5'h01, 8'h00, 8'h01, 8'h00, 1'b0));

        // Reset in the middle of a held write and read
        runVec("mid.wr",    makeVec(1'b0, 1'b1, 16'hFFFF, 8'h01, 5'h01, 8'h00, 8'h01, 8'h00, 1'b0));
        runVec("mid.rd",    makeVec(1'b1, 1'b1, 16'hFFFF, 8'h01, 5'h01, 8'h00, 8'h01, 8'h01, 1'b1));
        #2;
        n_reset = 1'b0;
        #1;
        checkOutput("mid.rst.irq", irq, 8'h00);
        checkOutput("mid.rst.rdata", rdata, 8'h00);
        checkOutput("mid.rst.oe", {7'd0, rdata_oe}, 8'h00);
        @(negedge clk);
        n_reset = 1'b1;
        runVec("mid.hold1", makeVec(1'b1, 1'b1, 16'hFFFF, 8'h01, 5'h01, 8'h00, 8'h00, 8'h00, 1'b1));
        runVec("mid.hold2", makeVec(1'b1, 1'b1, 16'hFFFF, 8'h01, 5'h01, 8'h00, 8'h00, 8'h00, 1'b1));
        runVec("mid.drop",  makeVec(1'b0, 1'b0, 16'hFFFF, 8'h01, 5'h01, 8'h00, 8'h00, 8'h00, 1'b0));
        runVec("mid.rise",  makeVec(1'b0, 1'b1, 16'hFFFF, 8'h01, 5'h01, 8'h00, 8'h00, 8'h00, 1'b0));
        runVec("mid.rdie",  makeVec(1'b1, 1'b0, 16'hFFFF, 8'h00, 5'h01, 8'h00, 8'h00, 8'h01, 1'b1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sm83_irq_ctl.md
SM83_IRQ_CTL -- requirements
Module: sm83_irq_ctl

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 5: number of interrupt sources, from VBlank (bit 0) to Joypad (bit 4).
REQ-002 SHALL provide parameter NUM_IRQS, default 8: width of the irq/iack vectors toward the CPU.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 n_reset  input  1  reset, asynchronous, active-low.
REQ-005 adr  input  16  CPU address bus.
REQ-006 wdata  input  8  CPU write data.
REQ-007 rd  input  1  CPU read strobe, active-high, level, may be held several clocks.
REQ-008 wr  input  1  CPU write strobe, active-high, level, may be held several clocks.
REQ-009 rdata  output  8  registered read data.
REQ-010 rdata_oe  output  1  registered, high when rdata is valid for a decoded read.
REQ-011 src  input  NUM_SRC  peripheral request levels, synchronous to clk.
REQ-012 irq  output  NUM_IRQS  pending-and-enabled requests to the CPU.
REQ-013 iack  input  NUM_IRQS  CPU acknowledge, normally one-hot.

Function
REQ-014 SHALL hold register IF[NUM_SRC-1:0] at address 0xFF0F and register IE[7:0] at address 0xFFFF.
REQ-015 Source edge detection:
- Keep a one-clock history of src.
- A 0->1 transition of src[i] (src[i]=1 and hist[i]=0) sets IF[i] on that clock edge.
- A source held high SHALL NOT set IF again.
REQ-016 Write commit:
- A write is committed only on the first clock where wr=1 and wr was 0 on the previous clock (registered wr_q).
- Holding wr therefore writes exactly once.
REQ-017 Committed write to 0xFF0F loads IF <= wdata[NUM_SRC-1:0]; wdata[7:5] are ignored.
REQ-018 Committed write to 0xFFFF loads IE <= wdata[7:0].
REQ-019 Writes to any other address SHALL have no effect.
REQ-020 iack[i]=1 for i<NUM_SRC clears IF[i] on that clock edge; multiple set iack bits clear each corresponding bit; iack[7:5] are ignored.
REQ-021 Same-bit priority per clock edge, highest first:
- source edge set, then
- iack clear, then
- CPU write, then
- hold.
- Worked case: a write of 0 to IF coincident with src[i] rising leaves IF[i]=1.
REQ-022 Read:
- On each clock where rd=1 and adr decodes, rdata/rdata_oe update on that edge (one clock latency) and stay valid while rd and adr remain.
- Read values: {3'b111, IF} for 0xFF0F; IE for 0xFFFF.
REQ-023 When rd=0 or adr is not decoded, rdata_oe SHALL be 0 on the next clock and rdata SHALL be 0x00.
REQ-024 A read SHALL return the IF value before any same-edge update; reading SHALL NOT clear IF.
REQ-025 irq SHALL be combinational: irq[i] = IF[i] & IE[i] for i<NUM_SRC, and irq[7:5] = 0.
REQ-026 irq SHALL reflect an IF/IE change in the same clock that the register changes (no extra latency beyond the register).

Reset
REQ-027 On n_reset=0, asynchronously: IF=0, IE=0, rdata=0x00, rdata_oe=0, wr_q=1.
REQ-028 On n_reset=0, the src history SHALL be set to all-ones, so that sources already high at release raise no request.
REQ-029 Reset asserted mid-write or mid-read SHALL abort the access, and after release the held wr SHALL NOT commit until it drops and rises again.
REQ-030 irq SHALL be 0 throughout reset.

Structure
REQ-031 Shared package sm83_pkg SHALL hold ADR_IF (0xFF0F), ADR_IE (0xFFFF), NUM_SRC and the source index constants (VBLANK=0, STAT=1, TIMER=2, SERIAL=3, JOYPAD=4).
REQ-032 The design SHALL contain one sub-module, sm83_edge_det: a parameterised-width rising-edge detector with reset-to-ones history, used for src and reused for wr.

Verification
REQ-033 Source set and clear: reset, write 0x1F to 0xFFFF, pulse src[2] for 1 clock -> IF=0x04, irq=0x04 on the next clock; assert iack=0x04 for 1 clock -> IF=0x00, irq=0x00.
REQ-034 Held write: hold wr=1 for 4 clocks with adr=0xFF0F, wdata=0x03, while src[0] rises on clock 3 -> IF=0x03 after commit; no re-commit; IF bit 0 remains 1; read of 0xFF0F returns 0xE3.
REQ-035 Simultaneous events: set IF=0x02, then in the same clock drive iack=0x02 and a src[1] rising edge -> IF[1]=1; next clock iack=0x02 only -> IF[1]=0.
REQ-036 Masking: IE=0x00, src[4] pulse -> IF=0x10, irq=0x00; write IE=0x10 -> irq=0x10 next clock; read 0xFFFF -> 0x10 with rdata_oe=1 one clock after rd; read 0xFF80 -> rdata_oe=0, rdata=0x00.
REQ-037 Reset behaviour: hold src=0x1F across n_reset release -> IF stays 0x00; assert n_reset mid-write with wr held high -> IE=0x00 immediately and no commit after release until wr toggles.
